pipe_scoreboard: RTL and testbench

Parametrised register scoreboard for the in-order pipeline: it tracks every in-flight register write from issue (leaving ID) through write-back and, per decode-stage source operand, decides whether to stall or forward and from which stage. It generalises fixed two-source, three-stage hazard/forwarding logic to any register count, pipeline depth, source count and load-use latency. It adds a deadlock watchdog and a stall-cycle counter. Sits beside the ID stage; its select outputs drive the EX-stage operand muxes.

---
 rtl/pipe_scoreboard.sv | 132 +++++++++++++
 tb/tb_pipe_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// Register scoreboard for the in-order pipeline: tracks in-flight register writes
// from EX to WB and resolves per-source stall/forward decisions for the ID stage.
module pipe_scoreboard #(
    parameter int REG_W      = 3,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_READY = 2,
    parameter int MAX_STALL  = 15,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic                          issue_we,
    input  logic                          issue_load,
    input  logic [REG_W-1:0]              issue_dst,
    input  logic [NSRC*REG_W-1:0]         src_addr,
    input  logic [NSRC-1:0]               src_used,
    input  logic                          flush,
    output logic                          stall,
    output logic [NSRC*SEL_W-1:0]         fwd_sel,
    output logic [$clog2(DEPTH+1)-1:0]    inflight,
    output logic [15:0]                   stall_count,
    output logic                          err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RUN_W = $clog2(MAX_STALL + 1);

    // Slot k holds the instruction that left ID k cycles ago (1 = EX, DEPTH = last).
    logic [DEPTH:1]             valid_q, valid_d;
    logic [DEPTH:1]             load_q, load_d;
    logic [DEPTH:1][REG_W-1:0]  dst_q, dst_d;

    logic [NSRC-1:0]            hazard;
    logic [NSRC*SEL_W-1:0]      fwd_sel_c;
    logic                       stall_c;
    logic [CNT_W-1:0]           inflight_c;

    logic [RUN_W-1:0]           run_q, run_d;
    logic [15:0]                stall_count_q, stall_count_d;
    logic                       err_q, err_d;

    // Scan oldest to youngest so the youngest matching producer overrides older ones.
    always_comb begin
        fwd_sel_c = '0;
        hazard    = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_used[i]) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    if (valid_q[k] && (dst_q[k] == src_addr[i*REG_W +: REG_W])) begin
                        fwd_sel_c[i*SEL_W +: SEL_W] = SEL_W'(k);
                        hazard[i] = load_q[k] && (k < LOAD_READY);
                    end
                end
            end
        end
    end

    always_comb begin
        stall_c = issue_valid && !flush && (|hazard);
    end

    always_comb begin
        inflight_c = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            inflight_c = inflight_c + CNT_W'(valid_q[k]);
        end
    end

    // A stalled or flushed instruction leaves a bubble in EX.
    always_comb begin
        valid_d    = '0;
        load_d     = '0;
        dst_d      = '0;
        valid_d[1] = issue_valid && issue_we && !stall_c && !flush;
        load_d[1]  = issue_load;
        dst_d[1]   = issue_dst;
        for (int k = 2; k <= DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            load_d[k]  = load_q[k-1];
            dst_d[k]   = dst_q[k-1];
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_c && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // run_q counts consecutive stall cycles; err latches when the run hits MAX_STALL.
    always_comb begin
        run_d = '0;
        err_d = err_q;
        if (stall_c) begin
            run_d = run_q;
            if (run_q != RUN_W'(MAX_STALL)) begin
                run_d = run_q + RUN_W'(1);
            end
            if (run_q >= RUN_W'(MAX_STALL - 1)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            load_q        <= '0;
            dst_q         <= '0;
            run_q         <= '0;
            stall_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            load_q        <= load_d;
            dst_q         <= dst_d;
            run_q         <= run_d;
            stall_count_q <= stall_count_d;
            err_q         <= err_d;
        end
    end

    assign stall       = stall_c;
    assign fwd_sel     = fwd_sel_c;
    assign inflight    = inflight_c;
    assign stall_count = stall_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: default build, a wide build (REG_W=4, DEPTH=4, NSRC=3)
// and a watchdog build (DEPTH=4, LOAD_READY=5, MAX_STALL=4) driven from shared inputs.
module tb_pipe_scoreboard;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv, iwe, ild, fl;
    logic [3:0] idst, s0, s1, s2;
    logic [2:0] used;

    logic        stall0, err0;
    logic [3:0]  fwd0;
    logic [1:0]  inf0;
    logic [15:0] scnt0;

    logic        stall1, err1;
    logic [8:0]  fwd1;
    logic [2:0]  inf1;
    logic [15:0] scnt1;

    logic        stall2, err2;
    logic [5:0]  fwd2;
    logic [2:0]  inf2;
    logic [15:0] scnt2;

    pipe_scoreboard dut0 (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_we(iwe), .issue_load(ild),
        .issue_dst(idst[2:0]), .src_addr({s1[2:0], s0[2:0]}), .src_used(used[1:0]),
        .flush(fl), .stall(stall0), .fwd_sel(fwd0), .inflight(inf0),
        .stall_count(scnt0), .err(err0)
    );

    pipe_scoreboard #(.REG_W(4), .DEPTH(4), .NSRC(3)) dut1 (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_we(iwe), .issue_load(ild),
        .issue_dst(idst), .src_addr({s2, s1, s0}), .src_used(used),
        .flush(fl), .stall(stall1), .fwd_sel(fwd1), .inflight(inf1),
        .stall_count(scnt1), .err(err1)
    );

    pipe_scoreboard #(.DEPTH(4), .LOAD_READY(5), .MAX_STALL(4)) dut2 (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_we(iwe), .issue_load(ild),
        .issue_dst(idst[2:0]), .src_addr({s1[2:0], s0[2:0]}), .src_used(used[1:0]),
        .flush(fl), .stall(stall2), .fwd_sel(fwd2), .inflight(inf2),
        .stall_count(scnt2), .err(err2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int step_no = 0;

    // Expected word: {stall, fwd0, fwd1, fwd2, inflight}, 4 bits each.
    logic [19:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", tag, step_no, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic ld, input logic [3:0] dst,
                         input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [2:0] u, input logic f);
        iv = v; iwe = we; ild = ld; idst = dst;
        s0 = a0; s1 = a1; s2 = a2; used = u; fl = f;
    endtask

    task automatic sb_compare();
        logic [19:0] w;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            w = exp_q.pop_front();
            check("d0_stall", 32'(stall0),     32'(w[19:16]));
            check("d0_fwd0",  32'(fwd0[1:0]),  32'(w[15:12]));
            check("d0_fwd1",  32'(fwd0[3:2]),  32'(w[11:8]));
            check("d0_infl",  32'(inf0),       32'(w[3:0]));
            check("d1_stall", 32'(stall1),     32'(w[19:16]));
            check("d1_fwd0",  32'(fwd1[2:0]),  32'(w[15:12]));
            check("d1_fwd1",  32'(fwd1[5:3]),  32'(w[11:8]));
            check("d1_fwd2",  32'(fwd1[8:6]),  32'(w[7:4]));
        end
    endtask

    // One ID-stage cycle: drive, queue the expectation, compare mid-cycle, advance.
    task automatic apply(input logic v, input logic we, input logic ld, input logic [3:0] dst,
                         input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [2:0] u, input logic f,
                         input logic [3:0] e_st, input logic [3:0] e_f0, input logic [3:0] e_f1,
                         input logic [3:0] e_f2, input logic [3:0] e_inf);
        step_no++;
        drive(v, we, ld, dst, a0, a1, a2, u, f);
        exp_q.push_back({e_st, e_f0, e_f1, e_f2, e_inf});
        @(negedge clk);
        sb_compare();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] e_inf);
        apply(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, e_inf);
    endtask

    task automatic tick_w(input logic e_stall, input logic e_err);
        step_no++;
        @(negedge clk);
        check("d2_stall", 32'(stall2), 32'(e_stall));
        check("d2_err",   32'(err2),   32'(e_err));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset(2);

        // Reset state, idle
        idle(0);
        check("d0_scnt_rst", 32'(scnt0), 32'd0);
        check("d0_err_rst",  32'(err0),  32'd0);
        check("d1_err_rst",  32'(err1),  32'd0);

        // ALU chain on r3: EX forward, then MEM forward on src1 (and src2 on wide build)
        apply(1, 1, 0, 3, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 3, 0, 0, 3'b001, 0, 0, 1, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 3, 3, 3'b110, 0, 0, 0, 2, 2, 1);
        idle(1);

        // Load-use on r2: one stall with forward select 1, then forward from slot 2
        apply(1, 1, 1, 2, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 2, 0, 0, 3'b001, 0, 1, 1, 0, 0, 1);
        check("d0_scnt_lu", 32'(scnt0), 32'd1);
        check("d1_scnt_lu", 32'(scnt1), 32'd1);
        apply(1, 0, 0, 0, 2, 0, 0, 3'b001, 0, 0, 2, 0, 0, 1);
        idle(1);

        // Youngest writer of r5 wins; unused matching source selects the register file
        apply(1, 1, 0, 5, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 5, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 5, 5, 0, 3'b001, 0, 0, 1, 0, 0, 2);
        idle(2);
        idle(1);

        // Flush beats load-use hazard and makes no slot 1 entry
        apply(1, 1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 4, 1, 0, 0, 3'b001, 1, 0, 1, 0, 0, 1);
        idle(1);
        check("d0_scnt_fl", 32'(scnt0), 32'd1);
        idle(1);
        idle(0);

        // Watchdog: load-use on a build where every slot is too early for load data
        do_reset(2);
        step_no++;
        drive(1, 1, 1, 2, 0, 0, 0, 3'b000, 0);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 2, 0, 0, 3'b001, 0);
        for (int c = 0; c < 4; c++) begin
            tick_w(1'b1, 1'b0);
        end
        check("d2_scnt", 32'(scnt2), 32'd4);
        tick_w(1'b0, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        tick_w(1'b0, 1'b1);
        tick_w(1'b0, 1'b1);
        do_reset(1);
        @(negedge clk);
        check("d2_err_clr",  32'(err2),  32'd0);
        check("d2_scnt_clr", 32'(scnt2), 32'd0);
        @(posedge clk);
        #1;

        // Reset during a stall: the clear wins and the stall is gone next cycle
        step_no++;
        drive(1, 1, 1, 2, 0, 0, 0, 3'b000, 0);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 2, 0, 0, 3'b001, 0);
        @(negedge clk);
        check("d0_stall_pre", 32'(stall0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("d0_stall_post", 32'(stall0),    32'd0);
        check("d0_fwd_post",   32'(fwd0),      32'd0);
        check("d0_infl_post",  32'(inf0),      32'd0);
        check("d0_scnt_post",  32'(scnt0),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
